// File: rtl/id_ctrl_sequencer.sv
// id_ctrl_sequencer: ID-stage main control decode into the ID/EX control register,
// with stall/flush/valid qualification and a HALT drain-and-park state machine.
module id_ctrl_sequencer #(
    parameter int          DRAIN_CYCLES = 4,
    parameter logic [5:0]  OP_HALT      = 6'b111111
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_valid,
    input  logic [5:0]  i_op,
    input  logic [5:0]  i_funct,
    input  logic        i_bus_a_is_zero,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_resume,
    output logic [13:0] o_ctrl_regs,
    output logic        o_ctrl_valid,
    output logic        o_redirect,
    output logic [1:0]  o_jmp_ctrl,
    output logic        o_fetch_stall,
    output logic        o_halted
);
    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J    = 6'b000010, OP_JAL  = 6'b000011,
                           OP_BEQ   = 6'b000100, OP_BNE  = 6'b000101, OP_ADDI = 6'b001000,
                           OP_SLTI  = 6'b001010, OP_ANDI = 6'b001100, OP_ORI  = 6'b001101,
                           OP_XORI  = 6'b001110, OP_LUI  = 6'b001111, OP_LB   = 6'b100000,
                           OP_LH    = 6'b100001, OP_LW   = 6'b100011, OP_LBU  = 6'b100100,
                           OP_LHU   = 6'b100101, OP_LWU  = 6'b100111, OP_SB   = 6'b101000,
                           OP_SH    = 6'b101001, OP_SW   = 6'b101011;
    localparam logic [5:0] FN_JR = 6'b001000, FN_JALR = 6'b001001;
    localparam logic [3:0] CNT_INIT = 4'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [13:0] r_ctrl;
    logic        r_valid;
    logic        r_halted;
    logic [13:0] w_dec;
    logic        w_run;

    // word layout: {next_pc_src, jmp[1:0], reg_write, reg_dst[1:0], mem_to_reg[1:0], mem_write, alu_src[1:0], alu_op[2:0]}
    always_comb begin
        w_dec = 14'h0000;
        case (i_op)
            OP_RTYPE: w_dec = (i_funct == FN_JR) ? 14'h3000 : (i_funct == FN_JALR) ? 14'h3502 : 14'h0502;
            OP_LW, OP_LWU: w_dec = 14'h0448;
            OP_LB, OP_LBU: w_dec = 14'h0488;
            OP_LH, OP_LHU: w_dec = 14'h04C8;
            OP_SW, OP_SB, OP_SH: w_dec = 14'h0028;
            OP_BEQ:  w_dec = i_bus_a_is_zero ? 14'h3801 : 14'h0001;
            OP_BNE:  w_dec = i_bus_a_is_zero ? 14'h0001 : 14'h3801;
            OP_ADDI: w_dec = 14'h040B;
            OP_SLTI: w_dec = 14'h040F;
            OP_ANDI: w_dec = 14'h0414;
            OP_ORI:  w_dec = 14'h0415;
            OP_XORI: w_dec = 14'h0416;
            OP_LUI:  w_dec = 14'h0418;
            OP_J:    w_dec = 14'h2800;
            OP_JAL:  w_dec = 14'h2E00;
            default: w_dec = 14'h0000;
        endcase
    end

    assign w_run         = (r_state == RUN);
    assign o_redirect    = w_run & w_dec[13];
    assign o_jmp_ctrl    = w_run ? w_dec[12:11] : 2'b00;
    assign o_fetch_stall = !w_run;
    assign o_ctrl_regs   = r_ctrl;
    assign o_ctrl_valid  = r_valid;
    assign o_halted      = r_halted;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= RUN;
            r_cnt    <= '0;
            r_ctrl   <= '0;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            // registered one edge behind HALTED entry, but drops on the resume edge itself
            r_halted <= (r_state == HALTED) && !i_resume;
            case (r_state)
                RUN: begin
                    if (i_flush || (!i_stall && !i_valid)) begin
                        r_ctrl  <= '0;
                        r_valid <= 1'b0;
                    end else if (!i_stall) begin
                        if (i_op == OP_HALT) begin
                            r_ctrl  <= '0;
                            r_valid <= 1'b0;
                            r_cnt   <= CNT_INIT;
                            r_state <= DRAIN;
                        end else begin
                            r_ctrl  <= w_dec;
                            r_valid <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    r_ctrl  <= '0;
                    r_valid <= 1'b0;
                    if (r_cnt == 4'd0) r_state <= HALTED;
                    else r_cnt <= r_cnt - 4'd1;
                end
                HALTED: begin
                    r_ctrl  <= '0;
                    r_valid <= 1'b0;
                    if (i_resume) r_state <= RUN;
                end
                default: r_state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_id_ctrl_sequencer.sv
// tb_id_ctrl_sequencer: vector table, HALT/reset sequences and random stimulus
// checked against a field-level reference model of the control stage.
module tb_id_ctrl_sequencer;
    localparam int DRAIN = 4;
    localparam logic [5:0] HALT = 6'b111111;

    logic        clk = 1'b0;
    logic        i_reset_n, i_valid, i_bus_a_is_zero, i_stall, i_flush, i_resume;
    logic [5:0]  i_op, i_funct;
    logic [13:0] o_ctrl_regs;
    logic        o_ctrl_valid, o_redirect, o_fetch_stall, o_halted;
    logic [1:0]  o_jmp_ctrl;

    int errors = 0;
    int checks = 0;

    id_ctrl_sequencer #(.DRAIN_CYCLES(DRAIN), .OP_HALT(HALT)) dut (
        .i_clk(clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .i_op(i_op), .i_funct(i_funct),
        .i_bus_a_is_zero(i_bus_a_is_zero), .i_stall(i_stall), .i_flush(i_flush), .i_resume(i_resume),
        .o_ctrl_regs(o_ctrl_regs), .o_ctrl_valid(o_ctrl_valid), .o_redirect(o_redirect),
        .o_jmp_ctrl(o_jmp_ctrl), .o_fetch_stall(o_fetch_stall), .o_halted(o_halted)
    );

    always #5 clk = ~clk;

    // reference model state: halt episode tracked as edges elapsed since the HALT accept
    bit          m_in_halt;
    int          m_age;
    logic [13:0] m_ctrl;
    bit          m_valid, m_halted;

    function automatic logic [13:0] pack(input bit ns, input logic [1:0] jmp, input bit rw,
                                         input logic [1:0] dst, input logic [1:0] m2r, input bit mw,
                                         input logic [1:0] src, input logic [2:0] alu);
        return {ns, jmp, rw, dst, m2r, mw, src, alu};
    endfunction

    function automatic logic [13:0] ref_dec(input logic [5:0] op, input logic [5:0] fn, input bit z);
        case (op)
            6'b000000: return fn == 6'b001000 ? pack(1, 2'b10, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000)
                            : fn == 6'b001001 ? pack(1, 2'b10, 1, 2'b01, 2'b00, 0, 2'b00, 3'b010)
                            : pack(0, 2'b00, 1, 2'b01, 2'b00, 0, 2'b00, 3'b010);
            6'b100011, 6'b100111: return pack(0, 2'b00, 1, 2'b00, 2'b01, 0, 2'b01, 3'b000);
            6'b100000, 6'b100100: return pack(0, 2'b00, 1, 2'b00, 2'b10, 0, 2'b01, 3'b000);
            6'b100001, 6'b100101: return pack(0, 2'b00, 1, 2'b00, 2'b11, 0, 2'b01, 3'b000);
            6'b101011, 6'b101000, 6'b101001: return pack(0, 2'b00, 0, 2'b00, 2'b00, 1, 2'b01, 3'b000);
            6'b000100, 6'b000101: return (z == (op == 6'b000100)) ? pack(1, 2'b11, 0, 2'b00, 2'b00, 0, 2'b00, 3'b001)
                                                                  : pack(0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 3'b001);
            6'b001000: return pack(0, 2'b00, 1, 2'b00, 2'b00, 0, 2'b01, 3'b011);
            6'b001010: return pack(0, 2'b00, 1, 2'b00, 2'b00, 0, 2'b01, 3'b111);
            6'b001100: return pack(0, 2'b00, 1, 2'b00, 2'b00, 0, 2'b10, 3'b100);
            6'b001101: return pack(0, 2'b00, 1, 2'b00, 2'b00, 0, 2'b10, 3'b101);
            6'b001110: return pack(0, 2'b00, 1, 2'b00, 2'b00, 0, 2'b10, 3'b110);
            6'b001111: return pack(0, 2'b00, 1, 2'b00, 2'b00, 0, 2'b11, 3'b000);
            6'b000010: return pack(1, 2'b01, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000);
            6'b000011: return pack(1, 2'b01, 1, 2'b10, 2'b00, 0, 2'b00, 3'b000);
            default:   return 14'h0000;
        endcase
    endfunction

    function automatic void model_reset();
        m_in_halt = 0; m_age = 0; m_ctrl = '0; m_valid = 0; m_halted = 0;
    endfunction

    function automatic void model_edge();
        if (!m_in_halt) begin
            if (i_flush) begin m_ctrl = '0; m_valid = 0; end
            else if (!i_stall) begin
                if (!i_valid) begin m_ctrl = '0; m_valid = 0; end
                else if (i_op == HALT) begin m_ctrl = '0; m_valid = 0; m_in_halt = 1; m_age = 0; end
                else begin m_ctrl = ref_dec(i_op, i_funct, i_bus_a_is_zero); m_valid = 1; end
            end
            m_halted = 0;
        end else begin
            m_ctrl = '0; m_valid = 0;
            if (m_age >= DRAIN && i_resume) begin m_in_halt = 0; m_halted = 0; end
            else begin m_age++; m_halted = (m_age >= DRAIN + 1); end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // comb outputs checked before the edge, registered outputs 1ns after it
    task automatic step(input string tag);
        logic [13:0] d;
        #2;
        d = ref_dec(i_op, i_funct, i_bus_a_is_zero);
        chk({tag, ".redirect"}, 32'(o_redirect), 32'(!m_in_halt && d[13]));
        chk({tag, ".jmp"}, 32'(o_jmp_ctrl), m_in_halt ? 0 : 32'(d[12:11]));
        chk({tag, ".fstall_pre"}, 32'(o_fetch_stall), 32'(m_in_halt));
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, ".ctrl"}, 32'(o_ctrl_regs), 32'(m_ctrl));
        chk({tag, ".cvalid"}, 32'(o_ctrl_valid), 32'(m_valid));
        chk({tag, ".halted"}, 32'(o_halted), 32'(m_halted));
        chk({tag, ".fstall"}, 32'(o_fetch_stall), 32'(m_in_halt));
    endtask

    task automatic drive(input bit v, input logic [5:0] op, input logic [5:0] fn, input bit z,
                         input bit st, input bit fl, input bit rs);
        i_valid = v; i_op = op; i_funct = fn; i_bus_a_is_zero = z; i_stall = st; i_flush = fl; i_resume = rs;
    endtask

    typedef struct {
        bit v; logic [5:0] op; logic [5:0] fn; bit z; bit st; bit fl;
        logic [13:0] ctrl; bit cv; bit rd; logic [1:0] jc;
    } vec_t;

    vec_t tv[$];
    logic [5:0] ops[20] = '{6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000101, 6'b001000, 6'b001010,
                            6'b001100, 6'b001101, 6'b001110, 6'b001111, 6'b100000, 6'b100001, 6'b100011,
                            6'b100100, 6'b100101, 6'b100111, 6'b101000, 6'b101001, 6'b101011};

    initial begin
        int edges;
        tv.push_back('{1, 6'b001000, 6'h00, 0, 0, 0, 14'h040B, 1, 0, 2'b00});
        tv.push_back('{1, 6'b000100, 6'h00, 1, 0, 0, 14'h3801, 1, 1, 2'b11});
        tv.push_back('{1, 6'b000100, 6'h00, 0, 0, 0, 14'h0001, 1, 0, 2'b00});
        tv.push_back('{1, 6'b000101, 6'h00, 0, 0, 0, 14'h3801, 1, 1, 2'b11});
        tv.push_back('{1, 6'b000000, 6'b001001, 0, 1, 0, 14'h3801, 1, 1, 2'b10});
        tv.push_back('{1, 6'b000000, 6'b001001, 0, 1, 0, 14'h3801, 1, 1, 2'b10});
        tv.push_back('{1, 6'b000000, 6'b001001, 0, 0, 0, 14'h3502, 1, 1, 2'b10});
        tv.push_back('{1, 6'b100011, 6'h00, 0, 1, 1, 14'h0000, 0, 0, 2'b00});
        tv.push_back('{1, 6'b010000, 6'h00, 0, 0, 0, 14'h0000, 1, 0, 2'b00});
        tv.push_back('{1, 6'b000010, 6'h00, 0, 0, 0, 14'h2800, 1, 1, 2'b01});
        tv.push_back('{1, 6'b000011, 6'h00, 0, 0, 0, 14'h2E00, 1, 1, 2'b01});
        tv.push_back('{1, 6'b100000, 6'h00, 0, 0, 0, 14'h0488, 1, 0, 2'b00});
        tv.push_back('{1, 6'b101001, 6'h00, 0, 0, 0, 14'h0028, 1, 0, 2'b00});
        tv.push_back('{1, 6'b000000, 6'b100000, 0, 0, 0, 14'h0502, 1, 0, 2'b00});
        tv.push_back('{1, 6'b000000, 6'b001000, 0, 0, 0, 14'h3000, 1, 1, 2'b10});
        tv.push_back('{1, 6'b001111, 6'h00, 0, 0, 0, 14'h0418, 1, 0, 2'b00});
        tv.push_back('{1, 6'b001110, 6'h00, 0, 0, 0, 14'h0416, 1, 0, 2'b00});
        tv.push_back('{0, 6'b001000, 6'h00, 0, 0, 0, 14'h0000, 0, 0, 2'b00});
        tv.push_back('{1, 6'b001010, 6'h00, 0, 0, 0, 14'h040F, 1, 0, 2'b00});
        tv.push_back('{1, 6'b001100, 6'h00, 0, 0, 0, 14'h0414, 1, 0, 2'b00});
        tv.push_back('{1, 6'b001101, 6'h00, 0, 0, 0, 14'h0415, 1, 0, 2'b00});
        tv.push_back('{1, 6'b100101, 6'h00, 0, 0, 0, 14'h04C8, 1, 0, 2'b00});
        tv.push_back('{1, 6'b100111, 6'h00, 0, 0, 0, 14'h0448, 1, 0, 2'b00});
        tv.push_back('{1, 6'b101011, 6'h00, 0, 1, 0, 14'h0448, 1, 0, 2'b00});
        tv.push_back('{1, 6'b101000, 6'h00, 0, 0, 0, 14'h0028, 1, 0, 2'b00});

        i_reset_n = 1'b0;
        drive(0, 6'h00, 6'h00, 0, 0, 0, 0);
        model_reset();
        #12;
        chk("reset.ctrl", 32'(o_ctrl_regs), 0);
        chk("reset.cvalid", 32'(o_ctrl_valid), 0);
        chk("reset.halted", 32'(o_halted), 0);
        chk("reset.fstall", 32'(o_fetch_stall), 0);
        @(negedge clk);
        i_reset_n = 1'b1;

        foreach (tv[i]) begin
            drive(tv[i].v, tv[i].op, tv[i].fn, tv[i].z, tv[i].st, tv[i].fl, 0);
            #2;
            chk($sformatf("vec%0d.redirect", i), 32'(o_redirect), 32'(tv[i].rd));
            chk($sformatf("vec%0d.jmp", i), 32'(o_jmp_ctrl), 32'(tv[i].jc));
            @(posedge clk);
            model_edge();
            #1;
            chk($sformatf("vec%0d.ctrl", i), 32'(o_ctrl_regs), 32'(tv[i].ctrl));
            chk($sformatf("vec%0d.cvalid", i), 32'(o_ctrl_valid), 32'(tv[i].cv));
        end

        // stalled HALT waits, then drains while ignoring ID inputs
        drive(1, HALT, 6'h00, 0, 1, 0, 0);
        step("halt_stalled");
        chk("halt_stalled.no_drain", 32'(o_fetch_stall), 0);
        drive(1, HALT, 6'h00, 0, 0, 1, 0);
        step("halt_flushed");
        chk("halt_flushed.no_drain", 32'(o_fetch_stall), 0);
        drive(1, HALT, 6'h00, 0, 0, 0, 0);
        step("halt_accept");
        chk("halt_accept.fstall", 32'(o_fetch_stall), 1);
        for (int k = 1; k <= DRAIN + 1; k++) begin
            drive(1, 6'b000000, 6'b100000, 0, k[0], k[1], 0);
            step($sformatf("drain%0d", k));
            chk($sformatf("drain%0d.halted_edge", k), 32'(o_halted), 32'(k == DRAIN + 1));
            chk($sformatf("drain%0d.ctrl_bubble", k), 32'(o_ctrl_regs), 0);
        end
        drive(0, 6'h00, 6'h00, 0, 0, 0, 1);
        step("resume");
        chk("resume.halted", 32'(o_halted), 0);
        chk("resume.fstall", 32'(o_fetch_stall), 0);

        // asynchronous reset mid-drain, then a full-length drain again
        drive(1, HALT, 6'h00, 0, 0, 0, 0);
        step("halt2_accept");
        drive(0, 6'h00, 6'h00, 0, 0, 0, 0);
        step("halt2_drain");
        #2;
        i_reset_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst.ctrl", 32'(o_ctrl_regs), 0);
        chk("async_rst.fstall", 32'(o_fetch_stall), 0);
        chk("async_rst.halted", 32'(o_halted), 0);
        chk("async_rst.cvalid", 32'(o_ctrl_valid), 0);
        @(negedge clk);
        i_reset_n = 1'b1;
        drive(1, HALT, 6'h00, 0, 0, 0, 0);
        step("halt3_accept");
        drive(0, 6'h00, 6'h00, 0, 0, 0, 0);
        edges = 0;
        for (int k = 1; k <= 20; k++) begin
            step("halt3_wait");
            edges = k;
            if (o_halted) break;
        end
        chk("halt3.latency", 32'(o_halted ? edges : 99), DRAIN + 1);
        drive(0, 6'h00, 6'h00, 0, 0, 0, 1);
        step("resume3");

        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 99) < 85,
                  ($urandom_range(0, 99) < 4) ? HALT : ops[$urandom_range(0, 19)],
                  ($urandom_range(0, 2) == 0) ? 6'(8 + $urandom_range(0, 1)) : 6'($urandom_range(0, 63)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10,
                  $urandom_range(0, 99) < 15);
            step($sformatf("rand%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/id_ctrl_sequencer.md
# id_ctrl_sequencer

Registered, parametrised main-control stage for the ID/EX boundary. Decodes opcode/funct into the 14-bit control word and latches it into the ID/EX control register, with stall (hold), flush (bubble) and an instruction-valid qualifier. Adds a HALT-drain state machine that stops fetch, lets the back end empty, and parks the core. Sits in ID between the instruction register and the ID/EX pipeline register. It also drives the fetch-side redirect and stall.

## Interface
- `DRAIN_CYCLES`, 4: cycles to hold after HALT before `o_halted`, range 1..15.
- `OP_HALT`, 6'b111111: opcode treated as HALT.
- `i_clk` input 1: clock, rising edge.
- `i_reset_n` input 1: reset, asynchronous assertion, active-low. Clears all state.
- `i_valid` input 1: ID holds a real instruction.
- `i_op` input 6: opcode.
- `i_funct` input 6: funct field.
- `i_bus_a_is_zero` input 1: rs==rt comparator result, valid in the same cycle.
- `i_stall` input 1: hazard stall. Hold all registers.
- `i_flush` input 1: squash the ID instruction. Load a bubble.
- `i_resume` input 1: one-cycle pulse that leaves HALTED.
- `o_ctrl_regs` output 14: registered control word.
- `o_ctrl_valid` output 1: registered; `o_ctrl_regs` holds a real instruction.
- `o_redirect` output 1: combinational; ID instruction changes PC (bit 13 of the decoded word).
- `o_jmp_ctrl` output 2: combinational; bits 12:11 of the decoded word.
- `o_fetch_stall` output 1: combinational; high in DRAIN and HALTED.
- `o_halted` output 1: registered; high in HALTED.

## Operation
- Control word fields:
  - b13 next_pc_src: 0 = seq, 1 = not seq.
  - b12:11 jmp: 00 = none, 01 = direct, 10 = register, 11 = branch.
  - b10 reg_write.
  - b9:8 reg_dst: 00 = rt, 01 = rd, 10 = GPR31.
  - b7:6 mem_to_reg: 00 = alu, 01 = word, 10 = byte, 11 = half.
  - b5 mem_write.
  - b4:3 alu_src: 00 = busB, 01 = sign-extended imm, 10 = zero-extended imm, 11 = upper imm.
  - b2:0 alu_op: 000 = load/store/jump, 001 = branch, 010 = R-type, 011 = addi, 100 = andi, 101 = ori, 110 = xori, 111 = slti.
- Bubble is 14'h0000. The default for any undefined opcode is also the bubble.
- Decode by opcode:
  - R-type: 1-seq? no — R-type = `{0,00,1,01,00,0,00,010}`.
  - JR (funct 001000): not-seq, jmp = reg, no write.
  - JALR (funct 001001): not-seq, jmp = reg, reg_write = 1, dst = rd, alu. This link write is new behaviour.
  - LW, LWU: rt, word, sign imm, 000. LB, LBU: byte. LH, LHU: half.
  - SW, SB, SH: mem_write, sign imm, 000.
  - BEQ: taken iff `i_bus_a_is_zero`. BNE: taken iff `!i_bus_a_is_zero`. Taken gives {1,11}, else {0,00}; alu 001.
  - ADDI, SLTI: sign imm. ANDI, ORI, XORI: zero imm. LUI: upper imm, 000. All write rt.
  - J: {1,01}. JAL: {1,01}, write GPR31.
- FSM states, reset state RUN:
  - RUN: an accepted instruction (`i_valid & !i_stall & !i_flush`) loads the decoded word with `o_ctrl_valid` = 1. If `i_op == OP_HALT`, load a bubble, set cnt = DRAIN_CYCLES-1, and go to DRAIN.
  - DRAIN: load a bubble every cycle, ignoring `i_stall`/`i_flush`/`i_valid`. If cnt == 0, go to HALTED; else cnt--.
  - HALTED: load a bubble. `i_resume` goes to RUN on the next edge.
- Outside RUN, `o_redirect` and `o_jmp_ctrl` are forced to 0.
- Precedence in RUN: flush > stall > accept. A flush during a stall loads a bubble.
- `!i_valid` (not stalled) loads a bubble.
- A HALT that is stalled is not accepted until the stall drops. A HALT that is flushed is discarded.
- Asynchronous reset mid-DRAIN returns to RUN with cnt = 0.

## Timing
- Reset values: `o_ctrl_regs` = 0, `o_ctrl_valid` = 0, `o_halted` = 0, `o_fetch_stall` = 0, state RUN.
- Decode to `o_ctrl_regs` takes 1 cycle. `o_redirect`/`o_jmp_ctrl` have 0-cycle latency, for same-cycle fetch redirect.
- `o_fetch_stall` rises the cycle after HALT is accepted.
- `o_halted` rises exactly DRAIN_CYCLES+1 edges after the HALT-accept edge.
- After `i_resume`, `o_halted` and `o_fetch_stall` fall on the next edge.
- `i_resume` outside HALTED is ignored.

## Test plan
- Reset sequence: `i_reset_n` low, then release → all outputs 0, state RUN. Drive ADDI (op 001000), valid → next edge `o_ctrl_regs` = 14'h040B (wait: `{0,00,1,00,00,0,01,011}` = 14'h040B), `o_ctrl_valid` = 1.
- BEQ with `i_bus_a_is_zero` = 1 → `o_redirect` = 1 and `o_jmp_ctrl` = 11 in the same cycle; registered word 14'h3801. With 0 → `o_redirect` = 0, word 14'h0001.
- JALR funct 001001 with `i_stall` = 1 for 2 cycles → output holds its previous value. After release → word 14'h3502.
- LW with `i_stall` = 1 and `i_flush` = 1 together → bubble 0, `o_ctrl_valid` = 0. Undefined opcode 010000 → bubble.
- HALT with DRAIN_CYCLES = 4 → `o_fetch_stall` = 1 next cycle; `o_halted` = 1 on the 5th edge after accept. Valid R-type, flush and stall during DRAIN have no effect. `i_resume` → RUN next edge.
- Assert `i_reset_n` low mid-DRAIN (cnt = 2), asynchronously between edges → outputs clear immediately. After release, a HALT drains the full DRAIN_CYCLES again.
